// File: rtl/fifo_uart_packer.sv
// fifo_uart_packer: packs a stream of 6-bit FIFO words LSB-first into bytes
// and transmits each byte as a UART 8N1 frame (CLK_DIV clocks per bit).
module fifo_uart_packer #(
   parameter int unsigned CLK_DIV = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       fifo_empty_n,
   input  logic [5:0] fifo_data,
   output logic       fifo_pop,
   input  logic       flush,
   output logic       tx,
   output logic       busy
);

   localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_t;

   state_t             state_q, state_d;
   logic [DIV_W-1:0]   div_q, div_d;
   logic [2:0]         idx_q, idx_d;
   logic [7:0]         sh_q, sh_d;
   logic [13:0]        acc_q, acc_d;
   logic [3:0]         cnt_q, cnt_d;
   logic               pop_q;
   logic               tx_q, tx_d;

   logic               load_full;
   logic               load_flush;
   logic [7:0]         flush_mask;
   logic [13:0]        acc_base;
   logic [3:0]         cnt_base;
   logic               div_last;

   // Pop request: room for another word and no pop in the previous cycle
   always_comb begin
      fifo_pop = !reset && fifo_empty_n && (cnt_q < 4'd8) && !pop_q;
   end

   // Accumulator: optional byte extraction, then optional append of the popped word
   always_comb begin
      load_full  = (state_q == IDLE) && (cnt_q >= 4'd8);
      load_flush = (state_q == IDLE) && (cnt_q != 4'd0) && (cnt_q < 4'd8)
                   && flush && !fifo_pop;
      flush_mask = (8'd1 << cnt_q[2:0]) - 8'd1;
      acc_base   = acc_q;
      cnt_base   = cnt_q;
      if (load_full) begin
         acc_base = acc_q >> 8;
         cnt_base = cnt_q - 4'd8;
      end else if (load_flush) begin
         acc_base = '0;
         cnt_base = '0;
      end
      acc_d = acc_base;
      cnt_d = cnt_base;
      if (fifo_pop) begin
         // Appending at the post-extraction count covers a load and a pop in one cycle
         acc_d = acc_base | (14'(fifo_data) << cnt_base);
         cnt_d = cnt_base + 4'd6;
      end
   end

   // Transmit FSM next state, bit-period counter, data index and line level
   always_comb begin
      state_d  = state_q;
      div_d    = div_q;
      idx_d    = idx_q;
      sh_d     = sh_q;
      div_last = (div_q == DIV_LAST);
      case (state_q)
         IDLE: begin
            if (load_full) begin
               sh_d    = acc_q[7:0];
               state_d = START;
               div_d   = '0;
               idx_d   = '0;
            end else if (load_flush) begin
               sh_d    = acc_q[7:0] & flush_mask;
               state_d = START;
               div_d   = '0;
               idx_d   = '0;
            end
         end
         START: begin
            if (div_last) begin
               state_d = DATA;
               div_d   = '0;
               idx_d   = '0;
            end else begin
               div_d = div_q + DIV_W'(1);
            end
         end
         DATA: begin
            if (div_last) begin
               div_d = '0;
               if (idx_q == 3'd7) begin
                  state_d = STOP;
                  idx_d   = '0;
               end else begin
                  idx_d = idx_q + 3'd1;
               end
            end else begin
               div_d = div_q + DIV_W'(1);
            end
         end
         STOP: begin
            if (div_last) begin
               state_d = IDLE;
               div_d   = '0;
               idx_d   = '0;
            end else begin
               div_d = div_q + DIV_W'(1);
            end
         end
         default: begin
            state_d = IDLE;
            div_d   = '0;
            idx_d   = '0;
         end
      endcase
      case (state_d)
         START:   tx_d = 1'b0;
         DATA:    tx_d = sh_d[idx_d];
         default: tx_d = 1'b1;
      endcase
   end

   // State registers; reset aborts any frame and discards buffered bits
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         div_q   <= '0;
         idx_q   <= '0;
         sh_q    <= '0;
         acc_q   <= '0;
         cnt_q   <= '0;
         pop_q   <= 1'b0;
         tx_q    <= 1'b1;
      end else begin
         state_q <= state_d;
         div_q   <= div_d;
         idx_q   <= idx_d;
         sh_q    <= sh_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         pop_q   <= fifo_pop;
         tx_q    <= tx_d;
      end
   end

   // Outputs
   always_comb begin
      tx   = tx_q;
      busy = (state_q != IDLE) || (cnt_q >= 4'd8);
   end

endmodule

// File: tb/tb_fifo_uart_packer.sv
// Testbench for fifo_uart_packer: upstream FIFO model, UART receiver monitor
// with an expected-byte scoreboard, and directed scenarios.
module tb_fifo_uart_packer;

   localparam int D = 4;

   logic       clk;
   logic       reset;
   logic       fifo_empty_n;
   logic [5:0] fifo_data;
   logic       fifo_pop;
   logic       flush;
   logic       tx;
   logic       busy;

   int         n_cmp  = 0;
   int         n_fail = 0;
   int         cyc    = 0;
   int         total_pops = 0;
   logic [5:0] fq[$];
   logic [7:0] exp_q[$];
   int         start_q[$];
   bit         in_frame = 0;
   int         k = 0;
   logic [7:0] rx = '0;
   bit         prev_tx = 1;
   bit         pop_cap = 0;
   bit         prev_pop = 0;

   fifo_uart_packer #(.CLK_DIV(D)) dut (
      .clk          (clk),
      .reset        (reset),
      .fifo_empty_n (fifo_empty_n),
      .fifo_data    (fifo_data),
      .fifo_pop     (fifo_pop),
      .flush        (flush),
      .tx           (tx),
      .busy         (busy)
   );

   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc++;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Upstream FIFO: consumes the head after an edge where fifo_pop was high
   initial begin
      fifo_empty_n = 0;
      fifo_data    = '0;
      forever begin
         @(posedge clk);
         #1;
         if (pop_cap && fq.size() != 0) void'(fq.pop_front());
         fifo_empty_n = (fq.size() != 0);
         fifo_data    = fifo_empty_n ? fq[0] : 6'($urandom);
      end
   end

   // Monitor: pop spacing checks and UART frame decode against the scoreboard
   always @(negedge clk) begin
      if (reset) begin
         in_frame = 0;
         prev_tx  = 1;
         pop_cap  = 0;
         prev_pop = 0;
      end else begin
         pop_cap = fifo_pop;
         if (fifo_pop) begin
            total_pops++;
            check("pop_spacing", 32'(prev_pop), 0);
            check("pop_nonempty", 32'(fifo_empty_n), 1);
         end
         prev_pop = fifo_pop;
         if (!in_frame) begin
            if (!tx && prev_tx) begin
               in_frame = 1;
               k = 0;
               rx = '0;
               start_q.push_back(cyc);
            end
         end else begin
            k++;
            if (k == D/2) check("start_bit", 32'(tx), 0);
            if (k >= D && k < 9*D && ((k - D) % D) == D/2) rx[(k - D) / D] = tx;
            if (k == 9*D + D/2) check("stop_bit", 32'(tx), 1);
            if (k == 10*D - 1) begin
               if (exp_q.size() == 0) begin
                  n_cmp++;
                  n_fail++;
                  $display("FAIL unexpected_frame: got %0h expected no frame (cycle %0d)", rx, cyc);
               end else begin
                  check("frame_byte", 32'(rx), 32'(exp_q.pop_front()));
               end
               in_frame = 0;
            end
         end
         prev_tx = tx;
      end
   end

   task automatic drain(input string name, input int limit);
      int i;
      for (i = 0; i < limit; i++) begin
         @(negedge clk);
         #1;
         if (exp_q.size() == 0 && !in_frame && !busy && fq.size() == 0) break;
      end
      if (i == limit) begin
         n_cmp++;
         n_fail++;
         $display("FAIL %s: timeout, %0d frames outstanding expected 0", name, exp_q.size());
      end
   endtask

   task automatic idle_check(input string name, input int n, input bit chk_pop);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         #1;
         check({name, "_tx"}, 32'(tx), 1);
         check({name, "_busy"}, 32'(busy), 0);
         if (chk_pop) check({name, "_pop"}, 32'(fifo_pop), 0);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      int pops_before;
      bit found;
      reset = 1;
      flush = 0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_tx", 32'(tx), 1);
      check("reset_pop", 32'(fifo_pop), 0);
      check("reset_busy", 32'(busy), 0);
      @(negedge clk);
      reset = 0;

      // Empty FIFO, no flush, nothing buffered
      idle_check("idle100", 100, 1);

      // Steady feed: 0x01..0x04 -> 0x81, 0x30, 0x10 with one idle cycle between frames
      @(negedge clk);
      start_q.delete();
      fq.push_back(6'h01); fq.push_back(6'h02); fq.push_back(6'h03); fq.push_back(6'h04);
      exp_q.push_back(8'h81); exp_q.push_back(8'h30); exp_q.push_back(8'h10);
      drain("steady", 500);
      check("frame_count", 32'(start_q.size()), 3);
      if (start_q.size() == 3) begin
         check("frame_gap1", 32'(start_q[1] - start_q[0]), 32'(10*D + 1));
         check("frame_gap2", 32'(start_q[2] - start_q[1]), 32'(10*D + 1));
      end
      check("steady_pops", 32'(total_pops), 4);

      // Single word then flush -> frame 0x3F, nothing further
      @(negedge clk);
      fq.push_back(6'h3F);
      exp_q.push_back(8'h3F);
      flush = 1;
      drain("flush_single", 200);
      idle_check("after_flush", 60, 1);
      check("flush_pops", 32'(total_pops), 5);
      flush = 0;

      // Leave two bits buffered: 0x3C,0x0F,0x33 -> 0xFC, 0x33
      @(negedge clk);
      fq.push_back(6'h3C); fq.push_back(6'h0F); fq.push_back(6'h33);
      exp_q.push_back(8'hFC); exp_q.push_back(8'h33);
      drain("two_left", 500);
      idle_check("hold2", 30, 1);
      // Flush in the same cycle as the pop at cnt=2 -> full byte 0xB7
      @(negedge clk);
      fq.push_back(6'h2D);
      exp_q.push_back(8'hB7);
      @(posedge clk);
      #2;
      flush = 1;
      drain("flush_with_pop", 200);
      idle_check("after_b7", 60, 1);
      flush = 0;

      // Continuous feed: three groups of 0x01..0x04
      @(negedge clk);
      pops_before = total_pops;
      for (int g = 0; g < 3; g++) begin
         fq.push_back(6'h01); fq.push_back(6'h02); fq.push_back(6'h03); fq.push_back(6'h04);
         exp_q.push_back(8'h81); exp_q.push_back(8'h30); exp_q.push_back(8'h10);
      end
      drain("continuous", 2000);
      check("continuous_pops", 32'(total_pops - pops_before), 12);

      // Reset during data bit 3 aborts the frame
      @(negedge clk);
      fq.push_back(6'h01); fq.push_back(6'h02);
      found = 0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         #1;
         if (in_frame && k == D + 3*D + 1) begin
            found = 1;
            break;
         end
      end
      check("reach_bit3", 32'(found), 1);
      reset = 1;
      #1;
      check("abort_tx", 32'(tx), 1);
      check("abort_busy", 32'(busy), 0);
      check("abort_pop", 32'(fifo_pop), 0);
      repeat (3) @(negedge clk);
      reset = 0;
      idle_check("post_reset", 60, 1);
      @(negedge clk);
      fq.push_back(6'h15); fq.push_back(6'h2A);
      exp_q.push_back(8'h95);
      drain("post_reset_stream", 300);
      idle_check("hold4", 60, 1);
      @(negedge clk);
      flush = 1;
      exp_q.push_back(8'h0A);
      drain("flush_hold4", 200);
      flush = 0;
      idle_check("final", 20, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
